// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Initiator side of the FPU start/done interface. Takes one request at a
//   time from the execute stage, launches the FPU with a single start pulse,
//   waits for done (bounded by a timeout), and hands the captured result back
//   over a valid/ready response channel. A sticky overflow flag records any
//   response that reported overflow until software clears it.
//
// Ports
//   clk, reset            system clock (rising edge), async active-high reset
//   req_*                 request channel (valid/ready, op, precision, operands)
//   fpu_start/op/...      drive side of the FPU; operands held between accepts
//   fpu_result/done/ovf   FPU completion inputs, sampled only while waiting
//   rsp_*                 response channel (valid/ready, result and status)
//   busy                  controller is not idle
//   overflow_sticky       set by an overflowed response, cleared by clear_sticky
//
// States
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a request; req_ready=1
//   ISSUE  | fpu_start high for this single cycle; timeout counter cleared
//   WAIT   | watching fpu_done; counting cycles toward the timeout
//   RESP   | rsp_valid=1, response held stable until rsp_ready

module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,   // 1..255
  parameter int CNT_W          = 8     // 2**CNT_W > TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_precision,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic        fpu_precision,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  input  logic        fpu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic        rsp_illegal,
  output logic        busy,
  output logic        overflow_sticky,
  input  logic        clear_sticky
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fpu_start_q, fpu_start_d;
  logic [1:0]        fpu_op_q, fpu_op_d;
  logic              fpu_prec_q, fpu_prec_d;
  logic [31:0]       fpu_a_q, fpu_a_d;
  logic [31:0]       fpu_b_q, fpu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic              sticky_q, sticky_d;
  logic              set_sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      fpu_start_q    <= 1'b0;
      fpu_op_q       <= 2'b00;
      fpu_prec_q     <= 1'b0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fpu_start_q    <= fpu_start_d;
      fpu_op_q       <= fpu_op_d;
      fpu_prec_q     <= fpu_prec_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
      rsp_illegal_q  <= rsp_illegal_d;
      sticky_q       <= sticky_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fpu_start_d    = 1'b0;
    fpu_op_d       = fpu_op_q;
    fpu_prec_d     = fpu_prec_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_illegal_d  = rsp_illegal_q;
    set_sticky     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fpu_op_d   = req_op;
          fpu_prec_d = req_precision;
          fpu_a_d    = req_precision ? {16'h0, req_a[15:0]} : req_a;
          fpu_b_d    = req_precision ? {16'h0, req_b[15:0]} : req_b;
          if (req_op[1]) begin
            // Illegal op: answer straight away without touching the FPU.
            state_d        = S_RESP;
            rsp_valid_d    = 1'b1;
            rsp_illegal_d  = 1'b1;
            rsp_timeout_d  = 1'b0;
            rsp_result_d   = '0;
            rsp_overflow_d = 1'b0;
          end else begin
            // Start is registered here so it is high exactly while in ISSUE.
            state_d     = S_ISSUE;
            fpu_start_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (fpu_done) begin
          state_d        = S_RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = fpu_prec_q ? {16'h0, fpu_result[15:0]} : fpu_result;
          rsp_overflow_d = fpu_overflow;
          rsp_timeout_d  = 1'b0;
          rsp_illegal_d  = 1'b0;
          set_sticky     = fpu_overflow;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_illegal_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d        = S_IDLE;
          rsp_valid_d    = 1'b0;
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b0;
          rsp_illegal_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A capture with overflow beats a simultaneous clear.
    if (set_sticky)        sticky_d = 1'b1;
    else if (clear_sticky) sticky_d = 1'b0;
    else                   sticky_d = sticky_q;
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign fpu_start       = fpu_start_q;
  assign fpu_op          = fpu_op_q;
  assign fpu_precision   = fpu_prec_q;
  assign fpu_a           = fpu_a_q;
  assign fpu_b           = fpu_b_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_overflow    = rsp_overflow_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign rsp_illegal     = rsp_illegal_q;
  assign overflow_sticky = sticky_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU start/done interface; the FPU itself is the responder.
- Accepts one floating-point request at a time from the execute stage over a valid/ready handshake.
- Drives the FPU operands and a one-cycle start pulse, waits for done with a timeout, captures result and overflow, and returns them over a valid/ready response handshake.
- Sits between the decoder/datapath and the fpu instance; also keeps a sticky overflow flag for status reads.

Parameters:
- TIMEOUT_CYCLES, 16, number of WAIT cycles without fpu_done before the request is aborted; legal range 1..255.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_op  input  2  00 add, 01 mul, 10/11 illegal.
- req_precision  input  1  0 single, 1 half.
- req_a  input  32  operand A.
- req_b  input  32  operand B.
- fpu_start  output  1  one-cycle start pulse to the FPU.
- fpu_op  output  2  latched op.
- fpu_precision  output  1  latched precision.
- fpu_a  output  32  latched operand A (masked in half mode).
- fpu_b  output  32  latched operand B (masked in half mode).
- fpu_result  input  32  FPU result.
- fpu_done  input  1  FPU completion.
- fpu_overflow  input  1  FPU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  32  captured result.
- rsp_overflow  output  1  captured overflow.
- rsp_timeout  output  1  request aborted by timeout.
- rsp_illegal  output  1  illegal op; the FPU was not started.
- busy  output  1  state != IDLE.
- overflow_sticky  output  1  set by any response with rsp_overflow=1.
- clear_sticky  input  1  clears overflow_sticky.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0. All registered outputs are 0: fpu_start, fpu_op, fpu_precision, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, rsp_illegal, overflow_sticky. busy=0.
- req_ready and busy are decoded combinationally from state, so req_ready=1 in the first cycle after reset release.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, on req_valid && req_ready:
  - Latch op, precision and operands.
  - If precision=1, the latched operands are {16'h0, req_x[15:0]}.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with rsp_illegal=1, rsp_result=0, rsp_overflow=0; the FPU is never started.
- ISSUE: fpu_start=1 for exactly this one cycle. counter cleared. Go to WAIT.
- WAIT: fpu_start=0. fpu_done is sampled only here; done seen during IDLE or ISSUE is ignored, which tolerates an FPU whose done is always high.
  - fpu_done=1: capture the result (if half precision, rsp_result={16'h0, fpu_result[15:0]}), capture rsp_overflow=fpu_overflow, rsp_timeout=0. Go to RESP.
  - fpu_done=0 and counter==TIMEOUT_CYCLES-1: rsp_timeout=1, rsp_result=0, rsp_overflow=0. Go to RESP.
  - Otherwise counter+1.
- RESP: rsp_valid=1, with all rsp_* held stable until rsp_ready. On rsp_ready go to IDLE; rsp_valid drops the next cycle and rsp_* flags clear to 0.
- fpu_op, fpu_precision, fpu_a and fpu_b are held from the accept edge until the next accept; they never change during ISSUE or WAIT.
- Latency for a legal op with an immediate done:
  - Accept edge at end of cycle 0.
  - fpu_start in cycle 1.
  - Capture at end of cycle 2.
  - rsp_valid from cycle 3.
  - If rsp_ready=1 in cycle 3, req_ready is back in cycle 4.
- Throughput is one request per 4 cycles at best. No request is accepted while busy.
- Sticky overflow:
  - Set on the RESP entry edge when the captured overflow is 1.
  - Cleared by clear_sticky.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation: the in-flight request is abandoned, no response is produced, and fpu_start is 0 immediately, asynchronously.
- Counter never wraps: it saturates at TIMEOUT_CYCLES-1 and the timeout exit takes priority.

Test Plan:
1. Add single: a=0x3F800000, b=0x40000000, op=00, stub FPU returns 0x40400000 with done=1 -> fpu_start pulses exactly one cycle; rsp_valid in cycle 3 with rsp_result=0x40400000, rsp_overflow=0; req_ready=0 during cycles 1-3.
2. Half precision: a=0xDEAD3C00, b=0xBEEF4000, op=01 -> fpu_a=0x00003C00, fpu_b=0x00004000; stub returns 0xFFFF4400 -> rsp_result=0x00004400.
3. Overflow and sticky: stub returns fpu_overflow=1 -> rsp_overflow=1 and overflow_sticky=1, staying 1 across a later clean op; clear_sticky pulse clears it; clear in the same cycle as a new overflow capture leaves it at 1.
4. Timeout: stub holds done=0 with TIMEOUT_CYCLES=16 -> rsp_valid with rsp_timeout=1 and rsp_result=0 exactly 16 WAIT cycles after the start pulse; a done arriving afterwards is ignored.
5. Illegal op=11 with backpressure: fpu_start never asserts; rsp_valid with rsp_illegal=1; rsp_ready held 0 for 5 cycles -> all rsp_* stable; rsp_ready=1 -> IDLE the next cycle.
6. Reset asserted asynchronously in WAIT -> state IDLE, all outputs 0 without a clock edge; after release req_ready=1 and a new add completes normally.
